ysyx_23060124_csr_seq: RTL and testbench

Multi-cycle sequencer that performs the CSR side effects of a retiring instruction through the single write port of the CSR file. It handles trap entry (ecall), trap return (mret) and explicit CSR writes, then hands the PC unit a redirect decision. It sits between the write-back stage and the CSR file / PC update logic. The write-back stage stalls on `o_pre_ready` while a sequence is in progress.

---
 rtl/ysyx_23060124_csr_seq_if.sv | 40 ++++
 rtl/ysyx_23060124_csr_seq.sv | 149 ++++++++++++++
 tb/tb_ysyx_23060124_csr_seq.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060124_csr_seq_if.sv
// Bundle between write-back stage, CSR sequencer, CSR file and PC unit.
// The sequencer is the slave; the retire/PC/CSR side is the master.
interface ysyx_23060124_csr_seq_if #(
    parameter int ISA_WIDTH = 32
);
    logic                 i_pre_valid;
    logic                 o_pre_ready;
    logic                 i_ecall;
    logic                 i_mret;
    logic                 i_csrw;
    logic [11:0]          i_csr_addr;
    logic [ISA_WIDTH-1:0] i_csr_wdata;
    logic [ISA_WIDTH-1:0] i_pc;
    logic [ISA_WIDTH-1:0] i_mtvec;
    logic [ISA_WIDTH-1:0] i_mepc;
    logic [ISA_WIDTH-1:0] i_mstatus;
    logic                 o_csr_wen;
    logic [11:0]          o_csr_waddr;
    logic [ISA_WIDTH-1:0] o_csr_wdata;
    logic                 o_post_valid;
    logic                 i_post_ready;
    logic                 o_pc_redirect;
    logic [ISA_WIDTH-1:0] o_pc_target;

    modport master (
        output i_pre_valid, i_ecall, i_mret, i_csrw,
        output i_csr_addr, i_csr_wdata, i_pc,
        output i_mtvec, i_mepc, i_mstatus, i_post_ready,
        input  o_pre_ready, o_csr_wen, o_csr_waddr, o_csr_wdata,
        input  o_post_valid, o_pc_redirect, o_pc_target
    );

    modport slave (
        input  i_pre_valid, i_ecall, i_mret, i_csrw,
        input  i_csr_addr, i_csr_wdata, i_pc,
        input  i_mtvec, i_mepc, i_mstatus, i_post_ready,
        output o_pre_ready, o_csr_wen, o_csr_waddr, o_csr_wdata,
        output o_post_valid, o_pc_redirect, o_pc_target
    );
endinterface

// File: rtl/ysyx_23060124_csr_seq.sv
// CSR side-effect sequencer: ecall / mret / csrw through one CSR write port,
// followed by a PC redirect decision held until the PC unit takes it.
module ysyx_23060124_csr_seq #(
    parameter int                   ISA_WIDTH    = 32,
    parameter logic [ISA_WIDTH-1:0] MCAUSE_ECALL = 32'd11
) (
    input logic                    clk,
    input logic                    i_rst_wbu,
    ysyx_23060124_csr_seq_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        E_MEPC,
        E_MCAUSE,
        E_MSTAT,
        R_MSTAT,
        C_WR,
        DONE
    } state_t;

    localparam logic [11:0] MSTATUS = 12'h300;
    localparam logic [11:0] MEPC    = 12'h341;
    localparam logic [11:0] MCAUSE  = 12'h342;

    state_t               state;
    logic                 wen;
    logic [11:0]          waddr;
    logic [ISA_WIDTH-1:0] wdata;
    logic                 post_valid;
    logic                 redirect;
    logic [ISA_WIDTH-1:0] target;
    logic [ISA_WIDTH-1:0] mstatus_q;
    logic [ISA_WIDTH-1:0] target_q;

    function automatic logic [ISA_WIDTH-1:0] trap_status(
        input logic [ISA_WIDTH-1:0] s
    );
        logic [ISA_WIDTH-1:0] r;
        r       = s;
        r[7]    = s[3];
        r[3]    = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [ISA_WIDTH-1:0] ret_status(
        input logic [ISA_WIDTH-1:0] s
    );
        logic [ISA_WIDTH-1:0] r;
        r       = s;
        r[3]    = s[7];
        r[7]    = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (i_rst_wbu) begin
            state      <= IDLE;
            wen        <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            post_valid <= 1'b0;
            redirect   <= 1'b0;
            target     <= '0;
            mstatus_q  <= '0;
            target_q   <= '0;
        end else begin
            wen   <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            unique case (state)
                IDLE: begin
                    if (bus.i_pre_valid) begin
                        mstatus_q <= bus.i_mstatus;
                        // first write is issued straight from the accept edge
                        if (bus.i_ecall) begin
                            state    <= E_MEPC;
                            wen      <= 1'b1;
                            waddr    <= MEPC;
                            wdata    <= bus.i_pc;
                            target_q <= bus.i_mtvec
                                      & {{(ISA_WIDTH-2){1'b1}}, 2'b00};
                        end else if (bus.i_mret) begin
                            state    <= R_MSTAT;
                            wen      <= 1'b1;
                            waddr    <= MSTATUS;
                            wdata    <= ret_status(bus.i_mstatus);
                            target_q <= bus.i_mepc;
                        end else if (bus.i_csrw) begin
                            state    <= C_WR;
                            wen      <= 1'b1;
                            waddr    <= bus.i_csr_addr;
                            wdata    <= bus.i_csr_wdata;
                            target_q <= '0;
                        end else begin
                            state      <= DONE;
                            post_valid <= 1'b1;
                            redirect   <= 1'b0;
                            target     <= '0;
                            target_q   <= '0;
                        end
                    end
                end
                E_MEPC: begin
                    state <= E_MCAUSE;
                    wen   <= 1'b1;
                    waddr <= MCAUSE;
                    wdata <= MCAUSE_ECALL;
                end
                E_MCAUSE: begin
                    state <= E_MSTAT;
                    wen   <= 1'b1;
                    waddr <= MSTATUS;
                    wdata <= trap_status(mstatus_q);
                end
                E_MSTAT, R_MSTAT: begin
                    state      <= DONE;
                    post_valid <= 1'b1;
                    redirect   <= 1'b1;
                    target     <= target_q;
                end
                C_WR: begin
                    state      <= DONE;
                    post_valid <= 1'b1;
                    redirect   <= 1'b0;
                    target     <= '0;
                end
                DONE: begin
                    if (bus.i_post_ready) begin
                        state      <= IDLE;
                        post_valid <= 1'b0;
                        redirect   <= 1'b0;
                        target     <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_pre_ready   = (state == IDLE);
    assign bus.o_csr_wen     = wen;
    assign bus.o_csr_waddr   = waddr;
    assign bus.o_csr_wdata   = wdata;
    assign bus.o_post_valid  = post_valid;
    assign bus.o_pc_redirect = redirect;
    assign bus.o_pc_target   = target;
endmodule

// File: tb/tb_ysyx_23060124_csr_seq.sv
// Directed bench for the CSR sequencer with a write/decision scoreboard.
module tb_ysyx_23060124_csr_seq;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_23060124_csr_seq_if #(.ISA_WIDTH(W)) bus ();

    ysyx_23060124_csr_seq #(
        .ISA_WIDTH(W),
        .MCAUSE_ECALL(32'd11)
    ) dut (
        .clk(clk),
        .i_rst_wbu(rst),
        .bus(bus)
    );

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic        redir;
        logic [31:0] tgt;
        int          cyc;
    } dec_t;

    wr_t  wq[$];
    dec_t dq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_t = 0;
    bit   mon_en = 1'b0;
    logic pv_prev = 1'b0;
    logic pr_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: every write and every decision must be expected.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.o_csr_wen === 1'b1) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexp_wr got addr %0h data %0h exp none",
                           bus.o_csr_waddr, bus.o_csr_wdata);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("wr_addr", 64'(bus.o_csr_waddr), 64'(e.addr));
                    chk("wr_data", 64'(bus.o_csr_wdata), 64'(e.data));
                    chk("wr_cyc", 64'(cyc), 64'(e.cyc));
                end
            end else begin
                chk("idle_waddr", 64'(bus.o_csr_waddr), 64'd0);
                chk("idle_wdata", 64'(bus.o_csr_wdata), 64'd0);
            end
            chk("pre_ready", 64'(bus.o_pre_ready),
                64'(!(bus.o_csr_wen || bus.o_post_valid)));
            if (bus.o_post_valid === 1'b1) begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexp_dec got redir %0b exp none",
                           bus.o_pc_redirect);
                end else begin
                    dec_t e;
                    e = dq[0];
                    if (!pv_prev || pr_prev)
                        chk("dec_cyc", 64'(cyc), 64'(e.cyc));
                    chk("dec_redir", 64'(bus.o_pc_redirect), 64'(e.redir));
                    chk("dec_tgt", 64'(bus.o_pc_target), 64'(e.tgt));
                    if (bus.i_post_ready === 1'b1) void'(dq.pop_front());
                end
            end
            pv_prev = bus.o_post_valid;
            pr_prev = bus.i_post_ready;
        end
    end

    task automatic scramble();
        bus.i_ecall     = 1'($urandom);
        bus.i_mret      = 1'($urandom);
        bus.i_csrw      = 1'($urandom);
        bus.i_csr_addr  = 12'($urandom);
        bus.i_csr_wdata = $urandom;
        bus.i_pc        = $urandom;
        bus.i_mtvec     = $urandom;
        bus.i_mepc      = $urandom;
        bus.i_mstatus   = $urandom;
    endtask

    // Call at posedge+1; returns at posedge+1 of the cycle after accept.
    task automatic issue(input bit e, input bit m, input bit c,
                         input logic [11:0] a, input logic [31:0] wd,
                         input logic [31:0] pc, input logic [31:0] tv,
                         input logic [31:0] ep, input logic [31:0] ms);
        int n;
        int t;
        logic [31:0] mse;
        logic [31:0] msm;
        n = 0;
        while (bus.o_pre_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.o_pre_ready !== 1'b1) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout got ready %0b exp 1", bus.o_pre_ready);
            return;
        end
        bus.i_ecall     = e;
        bus.i_mret      = m;
        bus.i_csrw      = c;
        bus.i_csr_addr  = a;
        bus.i_csr_wdata = wd;
        bus.i_pc        = pc;
        bus.i_mtvec     = tv;
        bus.i_mepc      = ep;
        bus.i_mstatus   = ms;
        bus.i_pre_valid = 1'b1;
        t = cyc;
        last_t = t;
        mse = (ms & ~32'h0000_1888) | 32'h0000_1800 | ((ms & 32'h8) << 4);
        msm = (ms & ~32'h0000_1888) | 32'h0000_1880 | ((ms & 32'h80) >> 4);
        if (e) begin
            wq.push_back('{12'h341, pc, t + 1});
            wq.push_back('{12'h342, 32'd11, t + 2});
            wq.push_back('{12'h300, mse, t + 3});
            dq.push_back('{1'b1, tv & 32'hFFFF_FFFC, t + 4});
        end else if (m) begin
            wq.push_back('{12'h300, msm, t + 1});
            dq.push_back('{1'b1, ep, t + 2});
        end else if (c) begin
            wq.push_back('{a, wd, t + 1});
            dq.push_back('{1'b0, 32'd0, t + 2});
        end else begin
            dq.push_back('{1'b0, 32'd0, t + 1});
        end
        @(posedge clk);
        #1;
        bus.i_pre_valid = 1'b0;
        scramble();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((wq.size() != 0 || dq.size() != 0) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_wq", 64'(wq.size()), 64'd0);
        chk("drain_dq", 64'(dq.size()), 64'd0);
    endtask

    initial begin
        int prev_t;
        int n;
        bus.i_pre_valid  = 1'b0;
        bus.i_post_ready = 1'b1;
        scramble();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_wen", 64'(bus.o_csr_wen), 64'd0);
        chk("rst_waddr", 64'(bus.o_csr_waddr), 64'd0);
        chk("rst_wdata", 64'(bus.o_csr_wdata), 64'd0);
        chk("rst_pvalid", 64'(bus.o_post_valid), 64'd0);
        chk("rst_redir", 64'(bus.o_pc_redirect), 64'd0);
        chk("rst_tgt", 64'(bus.o_pc_target), 64'd0);
        chk("rst_ready", 64'(bus.o_pre_ready), 64'd1);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 64'(bus.o_pre_ready), 64'd1);

        issue(1, 0, 0, 12'h000, 32'h0, 32'h8000_0010, 32'h8000_1003,
              32'h0, 32'h0000_0008);
        drain();

        issue(0, 1, 0, 12'h000, 32'h0, 32'h0, 32'h0,
              32'h8000_0014, 32'h0000_1880);
        drain();

        // Backpressure on a csrw, with a stray pre_valid during DONE.
        bus.i_post_ready = 1'b0;
        issue(0, 0, 1, 12'h305, 32'h8000_2000, 32'h0, 32'h0, 32'h0, 32'h0);
        n = 0;
        while (bus.o_post_valid !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_reach_done", 64'(bus.o_post_valid), 64'd1);
        bus.i_pre_valid = 1'b1;
        bus.i_ecall     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(bus.o_post_valid), 64'd1);
            chk("bp_redir", 64'(bus.o_pc_redirect), 64'd0);
            chk("bp_ready", 64'(bus.o_pre_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        bus.i_pre_valid  = 1'b0;
        bus.i_post_ready = 1'b1;
        drain();

        issue(1, 1, 0, 12'h000, 32'h0, 32'h8000_0100, 32'h8000_4002,
              32'h8000_9999, 32'h0000_0088);
        drain();

        issue(0, 1, 1, 12'h305, 32'h1234_5678, 32'h0, 32'h0,
              32'h8000_0200, 32'hFFFF_E77F);
        drain();

        issue(0, 0, 1, 12'h7C0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 32'h0);
        drain();

        prev_t = 0;
        for (int i = 0; i < 10; i++) begin
            issue(0, 0, 0, 12'h000, 32'h0, 32'h8000_0000 + 32'(4 * i),
                  32'h0, 32'h0, 32'h0);
            if (i > 0) chk("b2b_period", 64'(last_t - prev_t), 64'd2);
            prev_t = last_t;
        end
        drain();

        // Reset in the middle of E_MCAUSE abandons the trap sequence.
        issue(1, 0, 0, 12'h000, 32'h0, 32'h8000_0300, 32'h8000_5000,
              32'h0, 32'h0000_0008);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        wq.delete();
        dq.delete();
        chk("mid_rst_wen", 64'(bus.o_csr_wen), 64'd0);
        chk("mid_rst_pvalid", 64'(bus.o_post_valid), 64'd0);
        chk("mid_rst_ready", 64'(bus.o_pre_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rel_ready", 64'(bus.o_pre_ready), 64'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("rel_idle_wen", 64'(bus.o_csr_wen), 64'd0);

        issue(1, 0, 0, 12'h000, 32'h0, 32'h8000_0400, 32'h8000_6001,
              32'h0, 32'h0000_1808);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
